// File: rtl/if_fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// if_fetch_stage_pkg
// Shared definitions for the instruction-fetch stage and the downstream
// pipeline registers: datapath width, reset PC, bubble encoding, PC step,
// fetch FSM state encoding and a saturating counter helper.
// -----------------------------------------------------------------------------
package if_fetch_stage_pkg;

    localparam int          FETCH_DATA_WIDTH = 32;
    localparam logic [31:0] FETCH_RESET_PC   = 32'h0040_0000;
    localparam logic [31:0] FETCH_NOP_INSTR  = 32'h0000_0000;  // sll $0,$0,0
    localparam int          FETCH_PC_STEP    = 4;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } fetchState_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] satInc32(input logic [31:0] value);
        logic [31:0] result;
        if (value == 32'hFFFF_FFFF) begin
            result = value;
        end else begin
            result = value + 32'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/if_fetch_stage_skid.sv
// -----------------------------------------------------------------------------
// if_skid_buffer
// One-entry {instr, pcplus4} holding register used when an instruction
// returns from memory while decode is stalled.
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   load            capture inInstr/inPcPlus4, mark full
//   drain           entry consumed, mark empty
//   clear           discard the entry (wins over load and drain)
//   full            entry holds a valid instruction
//   outInstr/outPcPlus4  stored entry
// -----------------------------------------------------------------------------
module if_skid_buffer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  drain,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] inInstr,
    input  logic [DATA_WIDTH-1:0] inPcPlus4,
    output logic                  full,
    output logic [DATA_WIDTH-1:0] outInstr,
    output logic [DATA_WIDTH-1:0] outPcPlus4
);

    logic                  full_r;
    logic [DATA_WIDTH-1:0] instr_r;
    logic [DATA_WIDTH-1:0] pcPlus4_r;

    // Entry storage and occupancy flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full_r    <= 1'b0;
            instr_r   <= {DATA_WIDTH{1'b0}};
            pcPlus4_r <= {DATA_WIDTH{1'b0}};
        end else if (clear) begin
            full_r    <= 1'b0;
            instr_r   <= {DATA_WIDTH{1'b0}};
            pcPlus4_r <= {DATA_WIDTH{1'b0}};
        end else if (load) begin
            full_r    <= 1'b1;
            instr_r   <= inInstr;
            pcPlus4_r <= inPcPlus4;
        end else if (drain) begin
            full_r    <= 1'b0;
        end else begin
            full_r    <= full_r;
        end
    end

    assign full       = full_r;
    assign outInstr   = instr_r;
    assign outPcPlus4 = pcPlus4_r;

endmodule

// File: rtl/if_fetch_stage.sv
// -----------------------------------------------------------------------------
// if_fetch_stage
// Instruction-fetch stage of the 5-stage MIPS pipeline. Owns the PC, fetches
// from instruction memory over a req/ready handshake and drives the IF/ID
// pipeline register. A one-entry skid buffer catches a memory return that
// lands while decode is stalled.
// Ports:
//   clk, reset       clock, asynchronous active-low reset
//   Stall            hold IF/ID and fetch (load-use hazard)
//   Flush            active-low: squash IF/ID, redirect PC to RedirectPC
//   imem_req/addr    fetch request and address (address is the PC)
//   imem_ready/rdata memory return for the current address
//   IF_ID_Instr/PCPlus4/Valid  pipeline register toward decode
//   FetchBusy        request outstanding without a return this cycle
// Optional build macro IF_FETCH_PERF_EN adds saturating counters
//   StallCycles, FlushCount, WaitCycles.
// -----------------------------------------------------------------------------
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter int                    DATA_WIDTH = FETCH_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(FETCH_RESET_PC),
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = DATA_WIDTH'(FETCH_NOP_INSTR),
    parameter int                    PC_STEP    = FETCH_PC_STEP
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Stall,
    input  logic                  Flush,
    input  logic [DATA_WIDTH-1:0] RedirectPC,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_ready,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic [DATA_WIDTH-1:0] IF_ID_Instr,
    output logic [DATA_WIDTH-1:0] IF_ID_PCPlus4,
    output logic                  IF_ID_Valid,
    output logic                  FetchBusy
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [31:0]           StallCycles,
    output logic [31:0]           FlushCount,
    output logic [31:0]           WaitCycles
`endif
);

    localparam logic [DATA_WIDTH-1:0] STEP = DATA_WIDTH'(PC_STEP);

    fetchState_e           state_r;
    logic                  req_r;
    logic [DATA_WIDTH-1:0] pc_r;
    logic [DATA_WIDTH-1:0] ifIdInstr_r;
    logic [DATA_WIDTH-1:0] ifIdPcPlus4_r;
    logic                  ifIdValid_r;

    logic [DATA_WIDTH-1:0] pcPlusStep_s;
    logic                  skidLoad_s;
    logic                  skidDrain_s;
    logic                  skidClear_s;
    logic                  skidFull_s;
    logic [DATA_WIDTH-1:0] skidInstr_s;
    logic [DATA_WIDTH-1:0] skidPcPlus4_s;

    // Wraps modulo 2^DATA_WIDTH; no alignment check.
    assign pcPlusStep_s = pc_r + STEP;

    // Skid buffer control: fill on a return under stall, empty when decode frees up.
    always_comb begin
        skidLoad_s  = 1'b0;
        skidDrain_s = 1'b0;
        skidClear_s = 1'b0;
        if (!Flush) begin
            skidClear_s = 1'b1;
        end else if ((state_r == S_REQ) && imem_ready && Stall) begin
            skidLoad_s = 1'b1;
        end else if ((state_r == S_HOLD) && !Stall) begin
            skidDrain_s = 1'b1;
        end else begin
            skidLoad_s = 1'b0;
        end
    end

    if_skid_buffer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk        (clk),
        .reset      (reset),
        .load       (skidLoad_s),
        .drain      (skidDrain_s),
        .clear      (skidClear_s),
        .inInstr    (imem_rdata),
        .inPcPlus4  (pcPlusStep_s),
        .full       (skidFull_s),
        .outInstr   (skidInstr_s),
        .outPcPlus4 (skidPcPlus4_s)
    );

    // Fetch FSM, PC and IF/ID register; flush outranks stall.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= S_BOOT;
            req_r         <= 1'b0;
            pc_r          <= RESET_PC;
            ifIdInstr_r   <= NOP_INSTR;
            ifIdPcPlus4_r <= {DATA_WIDTH{1'b0}};
            ifIdValid_r   <= 1'b0;
        end else if (!Flush) begin
            // Any same-cycle memory return is for the squashed path.
            state_r       <= S_REQ;
            req_r         <= 1'b1;
            pc_r          <= RedirectPC;
            ifIdInstr_r   <= NOP_INSTR;
            ifIdPcPlus4_r <= {DATA_WIDTH{1'b0}};
            ifIdValid_r   <= 1'b0;
        end else begin
            case (state_r)
                S_BOOT: begin
                    state_r <= S_REQ;
                    req_r   <= 1'b1;
                end
                S_REQ: begin
                    if (imem_ready) begin
                        pc_r <= pcPlusStep_s;
                        if (Stall) begin
                            // Return parked in the skid buffer; stop requesting.
                            state_r <= S_HOLD;
                            req_r   <= 1'b0;
                        end else begin
                            ifIdInstr_r   <= imem_rdata;
                            ifIdPcPlus4_r <= pcPlusStep_s;
                            ifIdValid_r   <= 1'b1;
                        end
                    end else if (!Stall) begin
                        ifIdInstr_r   <= NOP_INSTR;
                        ifIdPcPlus4_r <= {DATA_WIDTH{1'b0}};
                        ifIdValid_r   <= 1'b0;
                    end else begin
                        ifIdValid_r <= ifIdValid_r;
                    end
                end
                S_HOLD: begin
                    if (!Stall) begin
                        state_r <= S_REQ;
                        req_r   <= 1'b1;
                        if (skidFull_s) begin
                            ifIdInstr_r   <= skidInstr_s;
                            ifIdPcPlus4_r <= skidPcPlus4_s;
                            ifIdValid_r   <= 1'b1;
                        end else begin
                            ifIdInstr_r   <= NOP_INSTR;
                            ifIdPcPlus4_r <= {DATA_WIDTH{1'b0}};
                            ifIdValid_r   <= 1'b0;
                        end
                    end else begin
                        state_r <= S_HOLD;
                    end
                end
                default: begin
                    state_r <= S_BOOT;
                    req_r   <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req      = req_r;
    assign imem_addr     = pc_r;
    assign IF_ID_Instr   = ifIdInstr_r;
    assign IF_ID_PCPlus4 = ifIdPcPlus4_r;
    assign IF_ID_Valid   = ifIdValid_r;
    assign FetchBusy     = (state_r == S_REQ) && !imem_ready;

`ifdef IF_FETCH_PERF_EN
    logic [31:0] stallCycles_r;
    logic [31:0] flushCount_r;
    logic [31:0] waitCycles_r;

    // Saturating event counters for stall, flush and memory-wait cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stallCycles_r <= 32'd0;
            flushCount_r  <= 32'd0;
            waitCycles_r  <= 32'd0;
        end else begin
            if (Stall && Flush) begin
                stallCycles_r <= satInc32(stallCycles_r);
            end
            if (!Flush) begin
                flushCount_r <= satInc32(flushCount_r);
            end
            if ((state_r == S_REQ) && !imem_ready) begin
                waitCycles_r <= satInc32(waitCycles_r);
            end
        end
    end

    assign StallCycles = stallCycles_r;
    assign FlushCount  = flushCount_r;
    assign WaitCycles  = waitCycles_r;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios plus a
// randomized run compared against a transaction-level reference model.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        Stall;
    logic        Flush;
    logic [31:0] RedirectPC;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] IF_ID_Instr;
    logic [31:0] IF_ID_PCPlus4;
    logic        IF_ID_Valid;
    logic        FetchBusy;

    // second instance with a reset PC at the top of the address space
    logic        wReset;
    logic        wStall;
    logic        wFlush;
    logic [31:0] wRedirectPC;
    logic        wReq;
    logic [31:0] wAddr;
    logic        wReady;
    logic [31:0] wRdata;
    logic [31:0] wInstr;
    logic [31:0] wPcPlus4;
    logic        wValid;
    logic        wBusy;

`ifdef IF_FETCH_PERF_EN
    logic [31:0] StallCycles, FlushCount, WaitCycles;
    logic [31:0] wStallCycles, wFlushCount, wWaitCycles;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    if_fetch_stage u_dut (
        .clk           (clk),
        .reset         (reset),
        .Stall         (Stall),
        .Flush         (Flush),
        .RedirectPC    (RedirectPC),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .IF_ID_Instr   (IF_ID_Instr),
        .IF_ID_PCPlus4 (IF_ID_PCPlus4),
        .IF_ID_Valid   (IF_ID_Valid),
        .FetchBusy     (FetchBusy)
`ifdef IF_FETCH_PERF_EN
        ,
        .StallCycles   (StallCycles),
        .FlushCount    (FlushCount),
        .WaitCycles    (WaitCycles)
`endif
    );

    if_fetch_stage #(
        .RESET_PC (32'hFFFF_FFFC)
    ) u_wrap (
        .clk           (clk),
        .reset         (wReset),
        .Stall         (wStall),
        .Flush         (wFlush),
        .RedirectPC    (wRedirectPC),
        .imem_req      (wReq),
        .imem_addr     (wAddr),
        .imem_ready    (wReady),
        .imem_rdata    (wRdata),
        .IF_ID_Instr   (wInstr),
        .IF_ID_PCPlus4 (wPcPlus4),
        .IF_ID_Valid   (wValid),
        .FetchBusy     (wBusy)
`ifdef IF_FETCH_PERF_EN
        ,
        .StallCycles   (wStallCycles),
        .FlushCount    (wFlushCount),
        .WaitCycles    (wWaitCycles)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; Stall = 1'b0; Flush = 1'b1; RedirectPC = 32'd0;
        imem_ready = 1'b0; imem_rdata = 32'd0;
        tick();
        tick();
        checks++;
        if ({imem_req, IF_ID_Valid, IF_ID_Instr, IF_ID_PCPlus4, imem_addr} !==
            {1'b0, 1'b0, 32'h0, 32'h0, 32'h0040_0000}) begin
            failures++;
            $display("FAIL reset_state: got req=%b v=%b i=%h p4=%h a=%h required 0 0 0 0 00400000",
                     imem_req, IF_ID_Valid, IF_ID_Instr, IF_ID_PCPlus4, imem_addr);
        end
`ifdef IF_FETCH_PERF_EN
        checks++;
        if ({StallCycles, FlushCount, WaitCycles} !== 96'd0) begin
            failures++;
            $display("FAIL reset_counters: got %h %h %h required 0", StallCycles, FlushCount, WaitCycles);
        end
`endif
    endtask

    task automatic test_stream();
        logic [31:0] data [3];
        data[0] = 32'h11; data[1] = 32'h22; data[2] = 32'h33;
        imem_ready = 1'b1;
        reset = 1'b1;
        tick();  // boot cycle, no request yet
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0040_0000}) begin
            failures++;
            $display("FAIL first_req: got req=%b addr=%h required 1 00400000", imem_req, imem_addr);
        end
        for (int k = 0; k < 3; k++) begin
            imem_rdata = data[k];
            tick();
            checks++;
            if ({IF_ID_Valid, IF_ID_Instr, IF_ID_PCPlus4, imem_addr} !==
                {1'b1, data[k], 32'h0040_0004 + 32'(4 * k), 32'h0040_0004 + 32'(4 * k)}) begin
                failures++;
                $display("FAIL stream_%0d: got v=%b i=%h p4=%h a=%h required 1 %h %h", k,
                         IF_ID_Valid, IF_ID_Instr, IF_ID_PCPlus4, imem_addr, data[k],
                         32'h0040_0004 + 32'(4 * k));
            end
        end
    endtask

    task automatic test_wait();
        // PC is now 0x0040000C
        imem_ready = 1'b0; Stall = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if ({FetchBusy, imem_addr} !== {1'b1, 32'h0040_000C}) begin
                failures++;
                $display("FAIL wait_busy_%0d: got busy=%b addr=%h required 1 0040000c", k, FetchBusy, imem_addr);
            end
            tick();
            checks++;
            if ({IF_ID_Valid, imem_addr} !== {1'b0, 32'h0040_000C}) begin
                failures++;
                $display("FAIL wait_bubble_%0d: got v=%b addr=%h required 0 0040000c", k, IF_ID_Valid, imem_addr);
            end
        end
        imem_ready = 1'b1; imem_rdata = 32'h44;
        #1;
        checks++;
        if (FetchBusy !== 1'b0) begin
            failures++;
            $display("FAIL wait_ready_busy: got %b required 0", FetchBusy);
        end
        tick();
        checks++;
        if ({IF_ID_Valid, IF_ID_Instr, IF_ID_PCPlus4, imem_addr} !==
            {1'b1, 32'h44, 32'h0040_0010, 32'h0040_0010}) begin
            failures++;
            $display("FAIL wait_capture: got v=%b i=%h p4=%h a=%h required 1 44 00400010 00400010",
                     IF_ID_Valid, IF_ID_Instr, IF_ID_PCPlus4, imem_addr);
        end
    endtask

    task automatic test_stall_skid();
        Stall = 1'b1; imem_ready = 1'b1; imem_rdata = 32'hAA;
        tick();
        checks++;
        if ({imem_req, IF_ID_Valid, IF_ID_Instr, imem_addr} !== {1'b0, 1'b1, 32'h44, 32'h0040_0014}) begin
            failures++;
            $display("FAIL skid_load: got req=%b v=%b i=%h a=%h required 0 1 44 00400014",
                     imem_req, IF_ID_Valid, IF_ID_Instr, imem_addr);
        end
        imem_ready = 1'b0; imem_rdata = 32'hBB;
        #1;
        checks++;
        if (FetchBusy !== 1'b0) begin
            failures++;
            $display("FAIL skid_hold_busy: got %b required 0", FetchBusy);
        end
        tick();
        checks++;
        if ({imem_req, IF_ID_Valid, IF_ID_Instr} !== {1'b0, 1'b1, 32'h44}) begin
            failures++;
            $display("FAIL skid_hold: got req=%b v=%b i=%h required 0 1 44", imem_req, IF_ID_Valid, IF_ID_Instr);
        end
        Stall = 1'b0;
        tick();
        checks++;
        if ({imem_req, IF_ID_Valid, IF_ID_Instr, IF_ID_PCPlus4, imem_addr} !==
            {1'b1, 1'b1, 32'hAA, 32'h0040_0014, 32'h0040_0014}) begin
            failures++;
            $display("FAIL skid_drain: got req=%b v=%b i=%h p4=%h a=%h required 1 1 aa 00400014 00400014",
                     imem_req, IF_ID_Valid, IF_ID_Instr, IF_ID_PCPlus4, imem_addr);
        end
        imem_ready = 1'b1; imem_rdata = 32'hCC;
        tick();
        checks++;
        if ({IF_ID_Instr, IF_ID_PCPlus4, imem_addr} !== {32'hCC, 32'h0040_0018, 32'h0040_0018}) begin
            failures++;
            $display("FAIL skid_resume: got i=%h p4=%h a=%h required cc 00400018 00400018",
                     IF_ID_Instr, IF_ID_PCPlus4, imem_addr);
        end
    endtask

    task automatic test_flush();
        Flush = 1'b0; RedirectPC = 32'h0040_0100; Stall = 1'b1; imem_ready = 1'b1; imem_rdata = 32'hDD;
        tick();
        checks++;
        if ({imem_req, IF_ID_Valid, IF_ID_Instr, IF_ID_PCPlus4, imem_addr} !==
            {1'b1, 1'b0, 32'h0, 32'h0, 32'h0040_0100}) begin
            failures++;
            $display("FAIL flush_req: got req=%b v=%b i=%h p4=%h a=%h required 1 0 0 0 00400100",
                     imem_req, IF_ID_Valid, IF_ID_Instr, IF_ID_PCPlus4, imem_addr);
        end
        Flush = 1'b1; Stall = 1'b0; imem_rdata = 32'hEE;
        tick();
        checks++;
        if ({IF_ID_Valid, IF_ID_Instr, IF_ID_PCPlus4} !== {1'b1, 32'hEE, 32'h0040_0104}) begin
            failures++;
            $display("FAIL flush_refetch: got v=%b i=%h p4=%h required 1 ee 00400104",
                     IF_ID_Valid, IF_ID_Instr, IF_ID_PCPlus4);
        end
        // flush while the skid buffer is full discards the parked instruction
        Stall = 1'b1; imem_rdata = 32'h55;
        tick();
        Flush = 1'b0; RedirectPC = 32'h0040_0200;
        tick();
        checks++;
        if ({imem_req, IF_ID_Valid, imem_addr} !== {1'b1, 1'b0, 32'h0040_0200}) begin
            failures++;
            $display("FAIL flush_hold: got req=%b v=%b a=%h required 1 0 00400200", imem_req, IF_ID_Valid, imem_addr);
        end
        Flush = 1'b1; Stall = 1'b0; imem_rdata = 32'h66;
        tick();
        checks++;
        if ({IF_ID_Valid, IF_ID_Instr, IF_ID_PCPlus4} !== {1'b1, 32'h66, 32'h0040_0204}) begin
            failures++;
            $display("FAIL flush_hold_refetch: got v=%b i=%h p4=%h required 1 66 00400204",
                     IF_ID_Valid, IF_ID_Instr, IF_ID_PCPlus4);
        end
    endtask

    task automatic test_reset_mid();
        // DUT is requesting; reset mid-cycle must drop the request at once
        Stall = 1'b0; imem_ready = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({imem_req, IF_ID_Valid, imem_addr} !== {1'b0, 1'b0, 32'h0040_0000}) begin
            failures++;
            $display("FAIL reset_mid_req: got req=%b v=%b a=%h required 0 0 00400000", imem_req, IF_ID_Valid, imem_addr);
        end
        tick();
        reset = 1'b1; imem_ready = 1'b1; imem_rdata = 32'h12;
        tick();
        tick();
        Stall = 1'b1; imem_rdata = 32'h77;
        tick();  // parked in S_HOLD
        checks++;
        if ({imem_req, IF_ID_Valid, IF_ID_Instr} !== {1'b0, 1'b1, 32'h12}) begin
            failures++;
            $display("FAIL reset_mid_pre: got req=%b v=%b i=%h required 0 1 12", imem_req, IF_ID_Valid, IF_ID_Instr);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({imem_req, IF_ID_Valid, IF_ID_Instr, imem_addr} !== {1'b0, 1'b0, 32'h0, 32'h0040_0000}) begin
            failures++;
            $display("FAIL reset_mid_hold: got req=%b v=%b i=%h a=%h required 0 0 0 00400000",
                     imem_req, IF_ID_Valid, IF_ID_Instr, imem_addr);
        end
`ifdef IF_FETCH_PERF_EN
        checks++;
        if ({StallCycles, FlushCount, WaitCycles} !== 96'd0) begin
            failures++;
            $display("FAIL reset_mid_counters: got %h %h %h required 0", StallCycles, FlushCount, WaitCycles);
        end
`endif
        tick();
        reset = 1'b1; Stall = 1'b0; imem_rdata = 32'h21;
        tick();
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0040_0000}) begin
            failures++;
            $display("FAIL reset_release_addr: got req=%b a=%h required 1 00400000", imem_req, imem_addr);
        end
        tick();
        checks++;
        if ({IF_ID_Valid, IF_ID_Instr, IF_ID_PCPlus4} !== {1'b1, 32'h21, 32'h0040_0004}) begin
            failures++;
            $display("FAIL reset_release_fetch: got v=%b i=%h p4=%h required 1 21 00400004",
                     IF_ID_Valid, IF_ID_Instr, IF_ID_PCPlus4);
        end
    endtask

`ifdef IF_FETCH_PERF_EN
    task automatic test_perf();
        reset = 1'b0; Stall = 1'b0; Flush = 1'b1; imem_ready = 1'b0;
        tick();
        reset = 1'b1;
        tick();  // boot: nothing counted
        Stall = 1'b1;
        tick();  // stall + wait
        Stall = 1'b0; Flush = 1'b0;
        tick();  // flush + wait
        Flush = 1'b1;
        checks++;
        if ({StallCycles, FlushCount, WaitCycles} !== {32'd1, 32'd1, 32'd2}) begin
            failures++;
            $display("FAIL perf_counts: got %0d %0d %0d required 1 1 2", StallCycles, FlushCount, WaitCycles);
        end
    endtask
`endif

    task automatic test_wrap();
        wStall = 1'b0; wFlush = 1'b1; wReady = 1'b1; wRdata = 32'h99;
        wReset = 1'b1;
        tick();
        checks++;
        if ({wReq, wAddr} !== {1'b1, 32'hFFFF_FFFC}) begin
            failures++;
            $display("FAIL wrap_first: got req=%b a=%h required 1 fffffffc", wReq, wAddr);
        end
        tick();
        checks++;
        if ({wValid, wInstr, wPcPlus4, wAddr} !== {1'b1, 32'h99, 32'h0, 32'h0}) begin
            failures++;
            $display("FAIL wrap_second: got v=%b i=%h p4=%h a=%h required 1 99 0 0", wValid, wInstr, wPcPlus4, wAddr);
        end
    endtask

    task automatic test_random();
        logic [63:0] pend [$];
        logic [63:0] entry;
        logic [31:0] mPc, mInstr, mPc4;
        logic        mValid, mBoot, expReq;
        reset = 1'b0; Stall = 1'b0; Flush = 1'b1; imem_ready = 1'b0;
        tick();
        reset = 1'b1;
        mPc = 32'h0040_0000; mBoot = 1'b1; mValid = 1'b0; mInstr = 32'h0; mPc4 = 32'h0;
        for (int n = 0; n < 600; n++) begin
            Flush      = ($urandom_range(0, 9) != 0);
            Stall      = ($urandom_range(0, 2) == 0);
            imem_ready = ($urandom_range(0, 2) != 0);
            imem_rdata = $urandom;
            RedirectPC = $urandom & 32'hFFFF_FFFC;
            #1;
            expReq = !mBoot && (pend.size() == 0);
            checks++;
            if ({imem_req, imem_addr, FetchBusy} !== {expReq, mPc, expReq && !imem_ready}) begin
                failures++;
                $display("FAIL rand_req_%0d: got req=%b a=%h busy=%b required %b %h %b", n,
                         imem_req, imem_addr, FetchBusy, expReq, mPc, expReq && !imem_ready);
            end
            @(posedge clk);
            if (!Flush) begin
                mPc = RedirectPC; mValid = 1'b0; mInstr = 32'h0; mPc4 = 32'h0;
                pend.delete(); mBoot = 1'b0;
            end else if (mBoot) begin
                mBoot = 1'b0;
            end else if (pend.size() != 0) begin
                if (!Stall) begin
                    entry = pend.pop_front();
                    mInstr = entry[63:32]; mPc4 = entry[31:0]; mValid = 1'b1;
                end
            end else if (imem_ready) begin
                if (Stall) begin
                    pend.push_back({imem_rdata, mPc + 32'd4});
                end else begin
                    mInstr = imem_rdata; mPc4 = mPc + 32'd4; mValid = 1'b1;
                end
                mPc = mPc + 32'd4;
            end else if (!Stall) begin
                mValid = 1'b0; mInstr = 32'h0;
            end
            #1;
            checks++;
            if ({IF_ID_Valid, IF_ID_Instr} !== {mValid, mInstr} ||
                (mValid && (IF_ID_PCPlus4 !== mPc4))) begin
                failures++;
                $display("FAIL rand_ifid_%0d: got v=%b i=%h p4=%h required %b %h %h", n,
                         IF_ID_Valid, IF_ID_Instr, IF_ID_PCPlus4, mValid, mInstr, mPc4);
            end
        end
    endtask

    initial begin
        wReset = 1'b0; wStall = 1'b0; wFlush = 1'b1; wRedirectPC = 32'd0;
        wReady = 1'b0; wRdata = 32'd0;
        test_reset();
        test_stream();
        test_wait();
        test_stall_skid();
        test_flush();
        test_reset_mid();
`ifdef IF_FETCH_PERF_EN
        test_perf();
`endif
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
